// File: rtl/audio_mixer_if.sv
// Bundle of the mixer's sample, control and status signals.
// The master side drives the channel inputs and mix_tick; the slave side
// is the mixer itself, returning the mixed sample and status flags.
interface audio_mixer_if #(
    parameter int NUM_CH  = 4,
    parameter int IN_W    = 20,
    parameter int OUT_W   = 16,
    parameter int SHIFT_W = 4
) ();
    logic [NUM_CH*IN_W-1:0]    sample_in;
    logic [NUM_CH-1:0]         sample_in_valid;
    logic [NUM_CH*SHIFT_W-1:0] shift;
    logic [NUM_CH-1:0]         mute;
    logic                      mix_tick;
    logic [OUT_W-1:0]          sample_out;
    logic                      sample_out_valid;
    logic                      clipped;
    logic                      busy;
    logic                      overrun;

    modport master (
        output sample_in, sample_in_valid, shift, mute, mix_tick,
        input  sample_out, sample_out_valid, clipped, busy, overrun
    );

    modport slave (
        input  sample_in, sample_in_valid, shift, mute, mix_tick,
        output sample_out, sample_out_valid, clipped, busy, overrun
    );
endinterface

// File: rtl/audio_mixer.sv
// N-channel audio mixer. Each channel keeps a sample-and-hold register; on
// mix_tick all channels are snapshotted, then one channel per cycle is
// attenuated (arithmetic right shift), optionally muted, and summed in a
// single adder. The sum is scaled to OUT_W, saturated and emitted as a
// one-cycle valid-qualified sample with a clip flag. A tick that arrives
// while a mix is still running is dropped and latches the sticky overrun.
module audio_mixer #(
    parameter int NUM_CH  = 4,
    parameter int IN_W    = 20,
    parameter int OUT_W   = 16,
    parameter int SHIFT_W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    audio_mixer_if.slave if_mix
);
    localparam int ACC_W = IN_W + $clog2(NUM_CH);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DROP  = IN_W - OUT_W;

    // Saturation bounds expressed in accumulator width
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_OUT   = 2'd2
    } state_e;

    state_e                  r_state;
    state_e                  w_state_nxt;

    logic signed [IN_W-1:0]  r_hold [NUM_CH];
    logic signed [IN_W-1:0]  r_snap [NUM_CH];
    logic signed [ACC_W-1:0] r_acc;
    logic [IDX_W-1:0]        r_ch_idx;

    logic [OUT_W-1:0]        r_sample_out;
    logic                    r_sample_out_valid;
    logic                    r_clipped;
    logic                    r_busy;
    logic                    r_overrun;

    logic signed [IN_W-1:0]  w_in    [NUM_CH];
    logic [SHIFT_W-1:0]      w_shift [NUM_CH];
    logic signed [ACC_W-1:0] w_ext;
    logic signed [ACC_W-1:0] w_term;
    logic signed [ACC_W-1:0] w_scaled;
    logic [OUT_W-1:0]        w_sat;
    logic                    w_clip;
    logic                    w_last_ch;

    // Split the flat channel buses into per-channel views
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            w_in[k]    = if_mix.sample_in[k*IN_W +: IN_W];
            w_shift[k] = if_mix.shift[k*SHIFT_W +: SHIFT_W];
        end
    end

    // Contribution of the channel currently being accumulated (shift/mute live)
    always_comb begin
        w_ext  = ACC_W'(r_snap[r_ch_idx]);
        w_term = '0;
        if (if_mix.mute[r_ch_idx]) begin
            w_term = '0;
        end else begin
            w_term = w_ext >>> w_shift[r_ch_idx];
        end
    end

    // Scale the full-precision sum to the output width and saturate it
    always_comb begin
        w_scaled = r_acc >>> DROP;
        w_sat    = w_scaled[OUT_W-1:0];
        w_clip   = 1'b0;
        if (w_scaled > SAT_MAX) begin
            w_sat  = OUT_W'(SAT_MAX);
            w_clip = 1'b1;
        end else if (w_scaled < SAT_MIN) begin
            w_sat  = OUT_W'(SAT_MIN);
            w_clip = 1'b1;
        end else begin
            w_sat  = w_scaled[OUT_W-1:0];
            w_clip = 1'b0;
        end
    end

    assign w_last_ch = (r_ch_idx == IDX_W'(NUM_CH - 1));

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE -> ACCUM on tick, ACCUM for NUM_CH cycles, one OUT cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (if_mix.mix_tick) begin
                    w_state_nxt = ST_ACCUM;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (w_last_ch) begin
                    w_state_nxt = ST_OUT;
                end else begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_OUT: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Holding registers load on their strobe regardless of mix state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_hold[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (if_mix.sample_in_valid[k]) begin
                    r_hold[k] <= w_in[k];
                end
            end
        end
    end

    // Snapshot, accumulator, output register and status flags
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_snap[k] <= '0;
            end
            r_acc              <= '0;
            r_ch_idx           <= '0;
            r_sample_out       <= '0;
            r_sample_out_valid <= 1'b0;
            r_clipped          <= 1'b0;
            r_busy             <= 1'b0;
            r_overrun          <= 1'b0;
        end else begin
            r_sample_out_valid <= 1'b0;
            r_busy             <= (w_state_nxt != ST_IDLE);
            if (if_mix.mix_tick && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (if_mix.mix_tick) begin
                        // A strobe in the tick cycle wins over the held value
                        for (int k = 0; k < NUM_CH; k++) begin
                            r_snap[k] <= if_mix.sample_in_valid[k] ? w_in[k] : r_hold[k];
                        end
                        r_acc    <= '0;
                        r_ch_idx <= '0;
                    end
                end
                ST_ACCUM: begin
                    r_acc    <= r_acc + w_term;
                    r_ch_idx <= r_ch_idx + IDX_W'(1);
                end
                ST_OUT: begin
                    r_sample_out       <= w_sat;
                    r_clipped          <= w_clip;
                    r_sample_out_valid <= 1'b1;
                end
                default: begin
                    r_sample_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign if_mix.sample_out       = r_sample_out;
    assign if_mix.sample_out_valid = r_sample_out_valid;
    assign if_mix.clipped          = r_clipped;
    assign if_mix.busy             = r_busy;
    assign if_mix.overrun          = r_overrun;
endmodule
